// File: rtl/neo_kmulti.sv
// neo_kmulti: multi-channel NEO detector, psi(c) = x[c]^2 - x[c-k]*x[c+k], with spike flag and count.
// Latency: center c is written 2 cycles after the read of sample c+k; one channel spans M+2+k cycles.
// Backpressure: none; reads are issued open-loop and the memory must answer the cycle after ren.
module neo_kmulti #(
  parameter int N    = 16,
  parameter int M    = 16,
  parameter int C    = 2,
  parameter int KMAX = 4
) (
  input  logic                                Clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(KMAX):0]               k_sel,
  input  logic signed [2*N:0]                 threshold,
  input  logic signed [N-1:0]                 rdata,
  output logic                                ren,
  output logic [$clog2(C)+$clog2(M)-1:0]      raddr,
  output logic                                wen,
  output logic [$clog2(C)+$clog2(M)-1:0]      waddr,
  output logic signed [2*N:0]                 wdata,
  output logic                                spike,
  output logic [$clog2(C*M):0]                spike_cnt,
  output logic                                busy,
  output logic                                done,
  output logic                                k_err
);

  localparam int IW = $clog2(M);
  localparam int CB = (C > 1) ? $clog2(C) : 1;
  localparam int AW = $clog2(C) + IW;
  localparam int KW = $clog2(KMAX) + 1;
  localparam int SW = $clog2(C*M) + 1;
  localparam int PW = 2*N + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [CB-1:0]        ch;
  logic [IW-1:0]        idx;
  logic [KW-1:0]        fcnt;
  logic [KW-1:0]        k_q;
  logic signed [PW-1:0] thr_q;

  // read-return stage: rvld marks the cycle rdata carries sample ridx
  logic                 rvld;
  logic [IW-1:0]        ridx;

  // win[t] holds x[ridx - t]; the incoming rdata is tap 0
  logic signed [N-1:0]  win [1:2*KMAX];

  logic [31:0]          k32;
  logic [31:0]          ridx32;
  logic                 ch_last;
  logic                 flush_end;
  logic                 accept;
  logic                 enter_read;
  logic [IW-1:0]        cidx;
  logic [IW-1:0]        fidx;
  logic signed [N-1:0]  x_c;
  logic signed [N-1:0]  x_m;
  logic signed [2*N-1:0] sq;
  logic signed [2*N-1:0] cr;
  logic signed [PW-1:0] psi;

  assign k32        = 32'(k_q);
  assign ridx32     = 32'(ridx);
  assign ch_last    = (ch == CB'(C-1));
  assign flush_end  = (state == S_FLUSH) && (fcnt == k_q);
  assign accept     = (state == S_IDLE) && start;
  assign enter_read = accept || (flush_end && !ch_last);
  assign cidx       = IW'(ridx32 - k32);
  assign fidx       = IW'(32'(M) - k32 + 32'(fcnt));

  assign ren   = (state == S_READ);
  assign raddr = AW'({ch, idx});
  assign busy  = (state == S_READ) || (state == S_DRAIN) || (state == S_FLUSH);
  assign done  = (state == S_DONE);

  // select the center (tap k) and far (tap 2k) samples for the current lag
  always_comb begin
    x_c = '0;
    x_m = '0;
    for (int t = 1; t <= 2*KMAX; t++) begin
      if (t == k32)     x_c = win[t];
      if (t == 2 * k32) x_m = win[t];
    end
  end

  // exact Teager energy: 2N-bit products, 2N+1-bit difference
  assign sq  = x_c * x_c;
  assign cr  = x_m * rdata;
  assign psi = $signed({sq[2*N-1], sq}) - $signed({cr[2*N-1], cr});

  // run sequencing: READ M cycles, DRAIN 1, FLUSH k+1, per channel
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ch    <= '0;
      idx   <= '0;
      fcnt  <= '0;
      k_q   <= KW'(1);
      thr_q <= '0;
      k_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            ch    <= '0;
            idx   <= '0;
            thr_q <= threshold;
            if (k_sel == '0 || 32'(k_sel) > 32'(KMAX)) begin
              k_q   <= KW'(1);
              k_err <= 1'b1;
            end else begin
              k_q   <= k_sel;
              k_err <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (idx == IW'(M-1)) begin
            state <= S_DRAIN;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          state <= S_FLUSH;
          fcnt  <= '0;
        end
        S_FLUSH: begin
          if (fcnt == k_q) begin
            if (ch_last) begin
              state <= S_DONE;
            end else begin
              state <= S_READ;
              ch    <= ch + 1'b1;
              idx   <= '0;
            end
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // register the read strobe so the next cycle knows which sample rdata holds
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rvld <= 1'b0;
      ridx <= '0;
    end else begin
      rvld <= ren;
      ridx <= idx;
    end
  end

  // sample window: cleared at each channel start, shifts on every returned sample
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int t = 1; t <= 2*KMAX; t++) win[t] <= '0;
    end else if (enter_read) begin
      for (int t = 1; t <= 2*KMAX; t++) win[t] <= '0;
    end else if (rvld) begin
      win[1] <= rdata;
      for (int t = 2; t <= 2*KMAX; t++) win[t] <= win[t-1];
    end
  end

  // result writes: pipeline centers from returned samples, then zero-filled tail centers
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wen   <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      spike <= 1'b0;
    end else if (rvld && ridx32 >= k32) begin
      wen   <= 1'b1;
      waddr <= AW'({ch, cidx});
      if (ridx32 < 2 * k32) begin
        // center c < k has no left neighbour at distance k
        wdata <= '0;
        spike <= 1'b0;
      end else begin
        wdata <= psi;
        spike <= (psi > thr_q);
      end
    end else if (state == S_FLUSH && fcnt < k_q) begin
      wen   <= 1'b1;
      waddr <= AW'({ch, fidx});
      wdata <= '0;
      spike <= 1'b0;
    end else begin
      wen   <= 1'b0;
      wdata <= '0;
      spike <= 1'b0;
    end
  end

  // spike counter: cleared on accepted start, saturating, held between runs
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      spike_cnt <= '0;
    end else if (accept) begin
      spike_cnt <= '0;
    end else if (spike && !(&spike_cnt)) begin
      spike_cnt <= spike_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_neo_kmulti.sv
// Bench for neo_kmulti: memory model answering reads, write monitor against a psi reference.
// Reference computes every center directly from the stored samples and the timing rules.
// Covers directed cases, invalid lag, mid-run start/parameter changes, random runs and reset abort.
module tb_neo_kmulti;

  localparam int N    = 16;
  localparam int M    = 16;
  localparam int C    = 2;
  localparam int KMAX = 4;
  localparam int TOT  = C * M;
  localparam longint CNT_MAX = 63;

  logic               Clk;
  logic               reset;
  logic               start;
  logic [2:0]         k_sel;
  logic signed [32:0] threshold;
  logic signed [15:0] rdata;
  logic               ren;
  logic [4:0]         raddr;
  logic               wen;
  logic [4:0]         waddr;
  logic signed [32:0] wdata;
  logic               spike;
  logic [5:0]         spike_cnt;
  logic               busy;
  logic               done;
  logic               k_err;

  neo_kmulti #(.N(N), .M(M), .C(C), .KMAX(KMAX)) dut (
    .Clk(Clk), .reset(reset), .start(start), .k_sel(k_sel), .threshold(threshold),
    .rdata(rdata), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr), .wdata(wdata),
    .spike(spike), .spike_cnt(spike_cnt), .busy(busy), .done(done), .k_err(k_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic signed [15:0] mem [0:TOT-1];
  longint exp_dat [0:TOT-1];
  longint exp_cyc [0:TOT-1];
  bit     exp_spk [0:TOT-1];
  longint obs_dat [0:TOT-1];

  bit mon_en = 0;
  int t0 = 0;
  int l_cur = 19;
  int wr_n, rd_n, rd_bad;

  initial Clk = 0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // memory: data for a read appears the cycle after ren, garbage otherwise
  bit       rd_pend = 0;
  int       rd_addr = 0;
  always @(negedge Clk) begin
    if (rd_pend) rdata = mem[rd_addr];
    else         rdata = 16'($urandom);
    rd_pend = ren;
    rd_addr = int'(raddr);
  end

  // monitor: read schedule and every write against the reference
  always @(negedge Clk) begin
    int rel, chm, offm, eam;
    bit erm;
    if (mon_en) begin
      rel = cyc - t0;
      erm = 0;
      eam = 0;
      if (rel >= 1 && rel <= C * l_cur) begin
        chm  = (rel - 1) / l_cur;
        offm = (rel - 1) % l_cur;
        erm  = (offm < M);
        eam  = chm * M + offm;
      end
      if (ren !== erm || (erm && int'(raddr) != eam)) rd_bad++;
      if (ren) rd_n++;
      if (wen) begin
        if (wr_n < TOT) begin
          chk_val("waddr", waddr, wr_n);
          chk_val("wdata", wdata, exp_dat[wr_n]);
          chk_val("spike", spike, exp_spk[wr_n]);
          chk_val("wcycle", rel, exp_cyc[wr_n]);
          obs_dat[wr_n] = wdata;
        end else begin
          chk_val("extra_write", wr_n + 1, TOT);
        end
        wr_n++;
      end
    end
  end

  task automatic run_case(input int ks, input longint thr, input bit poke_start);
    int kk, ll, rel;
    longint psi, cnt;
    bit seen;
    kk = (ks == 0 || ks > KMAX) ? 1 : ks;
    ll = M + 2 + kk;
    cnt = 0;
    for (int ch = 0; ch < C; ch++) begin
      for (int c = 0; c < M; c++) begin
        if (c < kk || c > M - 1 - kk) psi = 0;
        else psi = longint'(mem[ch*M+c]) * longint'(mem[ch*M+c])
                 - longint'(mem[ch*M+c-kk]) * longint'(mem[ch*M+c+kk]);
        exp_dat[ch*M+c] = psi;
        exp_spk[ch*M+c] = (c >= kk && c <= M - 1 - kk && psi > thr);
        exp_cyc[ch*M+c] = ch * ll + 3 + kk + c;
        if (exp_spk[ch*M+c]) cnt++;
      end
    end
    if (cnt > CNT_MAX) cnt = CNT_MAX;
    wr_n = 0; rd_n = 0; rd_bad = 0; l_cur = ll;
    @(negedge Clk);
    k_sel = 3'(ks); threshold = 33'(thr); start = 1;
    t0 = cyc; mon_en = 1;
    @(negedge Clk);
    start = 0;
    k_sel = 3'($urandom);
    threshold = 33'(longint'(int'($urandom)));
    seen = 0;
    rel = 0;
    for (int i = 0; i < 2 * C * ll + 20; i++) begin
      rel = cyc - t0;
      if (rel == 1) chk_val("busy_run", busy, 1);
      if (done) begin
        seen = 1;
        break;
      end
      start = poke_start && (rel == 20);
      @(negedge Clk);
    end
    start = 0;
    if (seen) begin
      chk_val("done_cycle", rel, C * ll + 1);
      chk_val("busy_at_done", busy, 0);
    end else begin
      chk_val("done_timeout", 0, 1);
    end
    mon_en = 0;
    chk_val("read_count", rd_n, TOT);
    chk_val("read_sched_bad", rd_bad, 0);
    chk_val("write_count", wr_n, TOT);
    chk_val("spike_cnt", spike_cnt, cnt);
    chk_val("k_err", k_err, (ks == 0 || ks > KMAX) ? 1 : 0);
    @(negedge Clk);
    chk_val("done_pulse", done, 0);
    repeat (3) @(negedge Clk);
    chk_val("spike_cnt_hold", spike_cnt, cnt);
  endtask

  task automatic fill_rand(input int span);
    for (int i = 0; i < TOT; i++) begin
      if (span == 0) mem[i] = 16'($urandom);
      else           mem[i] = 16'($signed($urandom_range(0, 2 * span)) - span);
    end
  endtask

  initial begin
    int quiet;
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    reset = 0; start = 0; k_sel = 0; threshold = 0; rdata = 0;
    for (int i = 0; i < TOT; i++) mem[i] = 0;
    repeat (3) @(negedge Clk);
    chk_val("reset_ctl", {ren, wen, spike, busy, done, k_err}, 0);
    chk_val("reset_addr", {raddr, waddr}, 0);
    chk_val("reset_wdata", wdata, 0);
    chk_val("reset_cnt", spike_cnt, 0);
    reset = 1;

    // constant input: every psi is zero, no spikes, done at 39
    for (int i = 0; i < TOT; i++) mem[i] = 100;
    run_case(1, 0, 0);

    // single impulse in channel 0
    for (int i = 0; i < TOT; i++) mem[i] = 0;
    mem[3] = 10;
    run_case(1, 50, 0);
    chk_val("impulse_c3", obs_dat[3], 100);
    chk_val("impulse_c2", obs_dat[2], 0);
    chk_val("impulse_c4", obs_dat[4], 0);

    // extreme values, lag 2
    for (int i = 0; i < TOT; i++) mem[i] = 0;
    mem[3] = 16'sh7FFF;
    mem[5] = 16'sh8000;
    mem[7] = 16'sh8000;
    run_case(2, 0, 0);
    chk_val("extreme_c5", obs_dat[5], 2147450880);
    chk_val("extreme_edge0", obs_dat[0], 0);
    chk_val("extreme_edge15", obs_dat[15], 0);

    // invalid lag, plus a start pulse in the middle of the run
    fill_rand(60);
    run_case(7, 0, 1);

    // random runs over all lag selections
    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) begin
        fill_rand(60);
        run_case($urandom_range(0, 7), longint'($urandom_range(0, 3000)) - 1000, 0);
      end else begin
        fill_rand(0);
        run_case($urandom_range(0, 7), longint'(int'($urandom)), 0);
      end
    end

    // reset in the middle of a run
    fill_rand(60);
    @(negedge Clk);
    k_sel = 1; threshold = -33'sd4294967296; start = 1;
    @(negedge Clk);
    start = 0;
    repeat (9) @(negedge Clk);
    reset = 0;
    #1;
    chk_val("abort_ctl", {ren, wen, spike, busy, done, k_err}, 0);
    chk_val("abort_addr", {raddr, waddr}, 0);
    chk_val("abort_wdata", wdata, 0);
    chk_val("abort_cnt", spike_cnt, 0);
    repeat (2) @(negedge Clk);
    reset = 1;
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (ren || wen || busy) quiet++;
    end
    chk_val("abort_quiet", quiet, 0);
    run_case(3, 100, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
